axil_uart_console: RTL
======================

// Module: axil_uart_console
// PURPOSE
//  AXI4-Lite slave that consumes picorv32_axi console/exit traffic and turns console bytes into a UART TX stream.
//  Sits on the CPU AXI bus beside the memory model, decoding BASE_ADDR..BASE_ADDR+0xF.
//  TXDATA writes are queued in a FIFO and serialised 8N1. EXIT writes latch a sticky exit code for the bench or SoC.
// PARAMETERS
//  BASE_ADDR   32'h1000_0000  decode base; match when addr[31:4]==BASE_ADDR[31:4]
//  CLK_DIV     16             clk cycles per UART bit, >=2
//  FIFO_DEPTH  16             TX FIFO entries, power of 2, 2..128
// PORTS
//  clk              in   1   clock, all state on rising edge
//  resetn           in   1   asynchronous active-low reset
//  s_axi_awvalid/awready   in/out  1    write address handshake
//  s_axi_awaddr     in   32  write address
//  s_axi_wvalid/wready     in/out  1    write data handshake
//  s_axi_wdata      in   32  write data
//  s_axi_wstrb      in   4   byte strobes
//  s_axi_bvalid/bready     out/in  1    write response, no resp code
//  s_axi_arvalid/arready   in/out  1    read address handshake
//  s_axi_araddr     in   32  read address
//  s_axi_rvalid/rready     out/in  1    read data handshake
//  s_axi_rdata      out  32  read data, registered
//  uart_tx          out  1   serial output, idle high
//  exit_valid       out  1   sticky; set by first EXIT write
//  exit_code        out  32  captured EXIT wdata
// BEHAVIOUR
//  Reset values:
//   - all ready/valid 0, rdata 0, uart_tx 1, exit_valid 0, exit_code 0
//   - FIFO empty, FSM IDLE
//   - reset mid-frame aborts the frame; uart_tx goes high asynchronously
//  Registers (offset = addr[3:2]):
//   - 0 TXDATA: W pushes wdata[7:0] if wstrb[0]; reads 0
//   - 1 EXIT: W with wstrb[0] sets exit_valid and loads exit_code; later writes update exit_code; reads exit_code
//   - 2 STATUS: RO; [0] empty, [1] full, [2] busy (FSM!=IDLE or !empty), [3] exit_valid, [15:8] level
//   - 3: RAZ/WI
//   - Non-decoded address: write discarded, read returns 0, response still given
//  Write channel:
//   - awready/wready are 1-cycle pulses; AW and W are accepted independently, each latched once
//   - bvalid rises on the edge after both are latched, with register side-effect on that same edge
//   - TXDATA write while FIFO full: bvalid withheld until an entry frees, no byte dropped
//   - bvalid held until bready; next AW/W accepted only once bvalid is low
//  Read channel:
//   - one outstanding; arready pulses when rvalid=0
//   - rvalid+rdata on the next edge, held until rready
//   - STATUS reflects state at the arready edge
//  TX FSM IDLE->START->DATA(8, LSB first)->[PARITY]->STOP; each state CLK_DIV cycles:
//   - IDLE with !empty: pop on next edge, enter START, uart_tx<=0
//   - Push at edge E into empty FIFO with FSM IDLE: start bit begins at E+1
//   - STOP end with !empty: pop and go directly to START, no idle gap; else IDLE
//   - Simultaneous push and pop when full is legal; level unchanged
//  EXIT does not stall or flush TX; pending bytes keep draining.
// CONFIGURATION
//  AXIL_UART_PARITY_EN defined: PARITY state inserted after DATA, even parity (XOR of data bits), frame 11 bits.
//  Not defined: 8N1, 10-bit frame, no PARITY state.
// TESTING
//  - Reset mid-frame: resetn=0 during DATA -> uart_tx=1 immediately; STATUS after reset = 0x0000_0001.
//  - Write 0x41 to TXDATA, CLK_DIV=16 -> uart_tx low at E+1 for 16 cycles; bits 1,0,0,0,0,0,1,0; stop 1; frame 160 cycles (176 and parity 0 with AXIL_UART_PARITY_EN).
//  - 17 TXDATA writes, FIFO_DEPTH=16, first frame active -> 17th bvalid stalls until first pop; all 17 bytes emitted back-to-back, no gaps.
//  - AW 3 cycles before W, then W before AW -> single bvalid per write, one push each, correct bytes.
//  - Write 0x0000_0000 to EXIT -> exit_valid=1, exit_code=0; read EXIT returns 0; STATUS[3]=1.
//  - Read 0x1000_0008 with 3 bytes queued and frame active -> rdata[15:8]=3, [2]=1, [0]=0; read 0x2000_0000 -> 0.

Source files
------------

// File: rtl/axil_uart_console.sv
`timescale 1ns/1ps
// AXI4-Lite console/exit slave: TXDATA bytes go through a FIFO into a UART serialiser.
// Define AXIL_UART_PARITY_EN to insert an even-parity bit (11-bit frames); default is 8N1.
module axil_uart_console #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] s_axi_rdata,
  output logic        uart_tx,
  output logic        exit_valid,
  output logic [31:0] exit_code
);
  // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
  // the source holds valid and payload stable until that edge.
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_t;

  tx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, level;
  logic          empty, full, pop, push, bit_end;

  logic [31:2]   aw_addr_q;
  logic [31:0]   w_data_q;
  logic          w_strb0_q, aw_got, w_got;
  logic          wr_hit, tx_wr, exit_wr, wr_fire;
  logic [31:0]   rd_mux, status;
  logic          unused_bits;

  assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wstrb[3:1]};

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(FIFO_DEPTH));
  assign bit_end = (cnt == CW'(CLK_DIV - 1));
  assign pop     = !empty && ((state == ST_IDLE) || (state == ST_STOP && bit_end));

  assign wr_hit  = (aw_addr_q[31:4] == BASE_ADDR[31:4]);
  assign tx_wr   = wr_hit && (aw_addr_q[3:2] == 2'd0) && w_strb0_q;
  assign exit_wr = wr_hit && (aw_addr_q[3:2] == 2'd1) && w_strb0_q;
  // A full FIFO stalls the response rather than dropping; a same-edge pop frees a slot.
  assign wr_fire = aw_got && w_got && !s_axi_bvalid && !(tx_wr && full && !pop);
  assign push    = wr_fire && tx_wr;

  assign status = {16'h0, 8'(level), 4'h0, exit_valid,
                   (state != ST_IDLE) || !empty, full, empty};

  always_comb begin
    rd_mux = '0;
    if (s_axi_araddr[31:4] == BASE_ADDR[31:4]) begin
      case (s_axi_araddr[3:2])
        2'd1:    rd_mux = exit_code;
        2'd2:    rd_mux = status;
        default: rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= s_axi_wdata_q_byte();
  end

  function automatic logic [7:0] s_axi_wdata_q_byte();
    return w_data_q[7:0];
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb0_q     <= 1'b0;
      aw_got        <= 1'b0;
      w_got         <= 1'b0;
      wr_ptr        <= '0;
      exit_valid    <= 1'b0;
      exit_code     <= '0;
    end else begin
      s_axi_awready <= s_axi_awvalid && !s_axi_awready && !aw_got && !s_axi_bvalid;
      s_axi_wready  <= s_axi_wvalid && !s_axi_wready && !w_got && !s_axi_bvalid;
      if (s_axi_awvalid && s_axi_awready) begin
        aw_addr_q <= s_axi_awaddr[31:2];
        aw_got    <= 1'b1;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_data_q  <= s_axi_wdata;
        w_strb0_q <= s_axi_wstrb[0];
        w_got     <= 1'b1;
      end
      if (wr_fire) begin
        s_axi_bvalid <= 1'b1;
        aw_got       <= 1'b0;
        w_got        <= 1'b0;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (exit_wr) begin
          exit_valid <= 1'b1;
          exit_code  <= w_data_q;
        end
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
    end else begin
      s_axi_arready <= s_axi_arvalid && !s_axi_arready && !s_axi_rvalid;
      if (s_axi_arvalid && s_axi_arready) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_mux;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  // The byte stays intact in shreg so the parity bit can be formed after the data bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      rd_ptr  <= '0;
      uart_tx <= 1'b1;
    end else if (pop) begin
      rd_ptr  <= rd_ptr + 1'b1;
      shreg   <= fifo_mem[rd_ptr[AW-1:0]];
      state   <= ST_START;
      cnt     <= '0;
      uart_tx <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: cnt <= '0;
        ST_START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= ST_DATA;
            uart_tx <= shreg[0];
          end else cnt <= cnt + 1'b1;
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef AXIL_UART_PARITY_EN
              state   <= ST_PARITY;
              uart_tx <= ^shreg;
`else
              state   <= ST_STOP;
              uart_tx <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shreg[3'(bit_idx + 3'd1)];
            end
          end else cnt <= cnt + 1'b1;
        end
`ifdef AXIL_UART_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            cnt     <= '0;
            state   <= ST_STOP;
            uart_tx <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
